// File: rtl/gsim_pkg.sv
// gsim_pkg: shared state encoding, accumulator sizing and saturation helper for gs_iter_solver.
package gsim_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_B_REQ,
        S_B_WAIT,
        S_ROW_REQ,
        S_ROW_WAIT,
        S_MAC,
        S_UPD,
        S_OUT,
        S_DONE
    } state_t;

    localparam int GSIM_SAT_W = 128;

    function automatic int gsim_acc_w(input int n, input int aw, input int xw);
        return aw + xw + $clog2(n);
    endfunction

    // Clamp a wide signed value to the range of a w-bit two's complement word.
    function automatic logic signed [GSIM_SAT_W-1:0] sat_xw(input logic signed [GSIM_SAT_W-1:0] v,
                                                             input int w);
        logic signed [GSIM_SAT_W-1:0] hi;
        logic signed [GSIM_SAT_W-1:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/gsim_row_mac.sv
// gsim_row_mac: off-diagonal row dot product sum_{j!=idx} a_j*x_j, registered once (latency 1).
module gsim_row_mac #(
    parameter int N    = 16,
    parameter int AW   = 16,
    parameter int XW   = 32,
    parameter int ACCW = 52
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N*AW-1:0]        i_row,
    input  logic [N*XW-1:0]        i_x,
    input  logic [$clog2(N)-1:0]   i_idx,
    output logic signed [ACCW-1:0] o_sum
);

    logic signed [AW+XW-1:0] prod [N];
    logic signed [ACCW-1:0]  sum_d;

    // The diagonal slot carries the reciprocal, not a_ii, so it is masked out.
    always_comb begin
        sum_d = '0;
        for (int j = 0; j < N; j++) begin
            prod[j] = $signed(i_row[j*AW +: AW]) * $signed(i_x[j*XW +: XW]);
            if (j != int'(i_idx)) sum_d = sum_d + ACCW'(prod[j]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_sum <= '0;
        else o_sum <= sum_d;
    end

endmodule

// File: rtl/gs_iter_solver.sv
// gs_iter_solver: batched Gauss-Seidel / Jacobi solver streaming rows from matrix memory to x memory.
// Define GSIM_EARLY_STOP_EN to end a matrix once a sweep (from the second on) moves no x_i by more than 1 LSB.
module gs_iter_solver
    import gsim_pkg::*;
#(
    parameter int N      = 16,
    parameter int AW     = 16,
    parameter int XW     = 32,
    parameter int XF     = 16,
    parameter int RF     = 14,
    parameter int ITER   = 16,
    parameter int MNW    = 5,
    parameter int MEM_AW = 10,
    parameter int X_AW   = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_module_en,
    input  logic              i_mode,
    input  logic [MNW-1:0]    i_matrix_num,
    output logic              o_proc_done,
    output logic              o_mem_rreq,
    output logic [MEM_AW-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [N*AW-1:0]   i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_x_wen,
    output logic [X_AW-1:0]   o_x_addr,
    output logic [XW-1:0]     o_x_data
);

    localparam int ACCW = gsim_acc_w(N, AW, XW);
    localparam int PW   = ACCW + 1 + AW;
    localparam int IW   = $clog2(N);
    localparam int SW   = $clog2(ITER + 1);

    state_t                st_q, st_d;
    logic                  mode_q, mode_d;
    logic [MNW-1:0]        mn_q, mn_d, m_q, m_d;
    logic [IW-1:0]         row_q, row_d, oi_q, oi_d;
    logic [SW-1:0]         sw_q, sw_d;
    logic [N*AW-1:0]       b_q, b_d, w_q, w_d;
    logic signed [XW-1:0]  x_q [N];
    logic signed [XW-1:0]  x_d [N];
    logic signed [XW-1:0]  xn_q [N];
    logic signed [XW-1:0]  xn_d [N];
    logic                  rreq_q, rreq_d, wen_q, wen_d, done_q, done_d;
    logic [MEM_AW-1:0]     addr_q, addr_d;
    logic [X_AW-1:0]       xaddr_q, xaddr_d;
    logic [XW-1:0]         xdata_q, xdata_d;
    logic [N*XW-1:0]       x_flat;
    logic signed [ACCW-1:0] s;
    logic signed [AW-1:0]  bi, ri;
    logic signed [ACCW:0]  num;
    logic signed [PW-1:0]  prod;
    logic signed [XW-1:0]  x_new;
    logic                  last_row, last_sweep;

    function automatic logic [MEM_AW-1:0] maddr(input logic [MNW-1:0] m, input int r);
        return MEM_AW'(int'(m) * (N + 1) + r);
    endfunction

    gsim_row_mac #(.N(N), .AW(AW), .XW(XW), .ACCW(ACCW)) u_mac (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_row (w_q),
        .i_x   (x_flat),
        .i_idx (row_q),
        .o_sum (s)
    );

    always_comb begin
        x_flat = '0;
        for (int k = 0; k < N; k++) x_flat[k*XW +: XW] = x_q[k];
    end

    // x_i = sat(((b_i << XF) - S) * r_i >>> RF); r_i == 0 marks a singular row.
    always_comb begin
        bi       = b_q[row_q*AW +: AW];
        ri       = w_q[row_q*AW +: AW];
        num      = ((ACCW+1)'(bi) <<< XF) - (ACCW+1)'(s);
        prod     = (PW'(num) * PW'(ri)) >>> RF;
        x_new    = (ri == '0) ? '0 : XW'(sat_xw(GSIM_SAT_W'(prod), XW));
        last_row = row_q == IW'(N - 1);
    end

`ifdef GSIM_EARLY_STOP_EN
    logic signed [XW:0] dif;
    logic [XW:0]        adif, mx_new, mx_q, mx_d;
    always_comb begin
        dif        = (XW+1)'(x_new) - (XW+1)'(x_q[row_q]);
        adif       = dif[XW] ? (XW+1)'(-dif) : (XW+1)'(dif);
        mx_new     = (adif > mx_q) ? adif : mx_q;
        mx_d       = (st_q == S_B_WAIT) ? '0 : (st_q == S_UPD) ? (last_row ? '0 : mx_new) : mx_q;
        last_sweep = (sw_q == SW'(ITER - 1)) || ((sw_q != '0) && (mx_new <= (XW+1)'(1)));
    end
`else
    always_comb last_sweep = sw_q == SW'(ITER - 1);
`endif

    always_comb begin
        st_d    = st_q;
        mode_d  = mode_q;
        mn_d    = mn_q;
        m_d     = m_q;
        row_d   = row_q;
        oi_d    = oi_q;
        sw_d    = sw_q;
        b_d     = b_q;
        w_d     = w_q;
        x_d     = x_q;
        xn_d    = xn_q;
        rreq_d  = rreq_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        xaddr_d = xaddr_q;
        xdata_d = xdata_q;
        done_d  = 1'b0;
        if (!i_module_en && st_q != S_IDLE) begin
            st_d   = S_IDLE;
            rreq_d = 1'b0;
        end else begin
            case (st_q)
                S_IDLE: if (i_module_en) begin
                    mode_d = i_mode;
                    mn_d   = i_matrix_num;
                    m_d    = '0;
                    if (i_matrix_num == '0) begin
                        st_d   = S_DONE;
                        done_d = 1'b1;
                    end else begin
                        st_d   = S_B_REQ;
                        rreq_d = 1'b1;
                        addr_d = maddr('0, N);
                        x_d    = '{default: '0};
                        xn_d   = '{default: '0};
                    end
                end
                S_B_REQ: if (i_mem_rrdy) begin
                    rreq_d = 1'b0;
                    st_d   = S_B_WAIT;
                end
                S_B_WAIT: if (i_mem_dout_vld) begin
                    b_d    = i_mem_dout;
                    st_d   = S_ROW_REQ;
                    rreq_d = 1'b1;
                    addr_d = maddr(m_q, 0);
                    row_d  = '0;
                    sw_d   = '0;
                end
                S_ROW_REQ: if (i_mem_rrdy) begin
                    rreq_d = 1'b0;
                    st_d   = S_ROW_WAIT;
                end
                S_ROW_WAIT: if (i_mem_dout_vld) begin
                    w_d  = i_mem_dout;
                    st_d = S_MAC;
                end
                S_MAC: st_d = S_UPD;
                S_UPD: begin
                    if (mode_q) xn_d[row_q] = x_new;
                    else x_d[row_q] = x_new;
                    if (last_row && mode_q) x_d = xn_d;
                    if (last_row && last_sweep) begin
                        st_d = S_OUT;
                        oi_d = '0;
                    end else begin
                        st_d   = S_ROW_REQ;
                        rreq_d = 1'b1;
                        row_d  = last_row ? '0 : row_q + 1'b1;
                        sw_d   = last_row ? sw_q + 1'b1 : sw_q;
                        addr_d = maddr(m_q, last_row ? 0 : int'(row_q) + 1);
                    end
                end
                S_OUT: begin
                    wen_d   = 1'b1;
                    xaddr_d = X_AW'(int'(m_q) * N + int'(oi_q));
                    xdata_d = x_q[oi_q];
                    oi_d    = oi_q + 1'b1;
                    if (oi_q == IW'(N - 1)) begin
                        if (m_q + 1'b1 == mn_q) begin
                            st_d   = S_DONE;
                            done_d = 1'b1;
                        end else begin
                            m_d    = m_q + 1'b1;
                            st_d   = S_B_REQ;
                            rreq_d = 1'b1;
                            addr_d = maddr(m_q + 1'b1, N);
                            x_d    = '{default: '0};
                            xn_d   = '{default: '0};
                        end
                    end
                end
                S_DONE: done_d = 1'b1;
                default: st_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q    <= S_IDLE;
            mode_q  <= 1'b0;
            mn_q    <= '0;
            m_q     <= '0;
            row_q   <= '0;
            oi_q    <= '0;
            sw_q    <= '0;
            b_q     <= '0;
            w_q     <= '0;
            x_q     <= '{default: '0};
            xn_q    <= '{default: '0};
            rreq_q  <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            xaddr_q <= '0;
            xdata_q <= '0;
            done_q  <= 1'b0;
`ifdef GSIM_EARLY_STOP_EN
            mx_q    <= '0;
`endif
        end else begin
            st_q    <= st_d;
            mode_q  <= mode_d;
            mn_q    <= mn_d;
            m_q     <= m_d;
            row_q   <= row_d;
            oi_q    <= oi_d;
            sw_q    <= sw_d;
            b_q     <= b_d;
            w_q     <= w_d;
            x_q     <= x_d;
            xn_q    <= xn_d;
            rreq_q  <= rreq_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            xaddr_q <= xaddr_d;
            xdata_q <= xdata_d;
            done_q  <= done_d;
`ifdef GSIM_EARLY_STOP_EN
            mx_q    <= mx_d;
`endif
        end
    end

    assign o_proc_done = done_q;
    assign o_mem_rreq  = rreq_q;
    assign o_mem_addr  = addr_q;
    assign o_x_wen     = wen_q;
    assign o_x_addr    = xaddr_q;
    assign o_x_data    = xdata_q;

endmodule

// File: tb/tb_gs_iter_solver.sv
// tb_gs_iter_solver: randomized batches against a plain-arithmetic solver model, plus literal spot checks.
module tb_gs_iter_solver;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int XW   = 32;
    localparam int ITER = 16;

    logic            clk, rst, en, mode;
    logic [4:0]      mnum;
    logic            o_proc_done, o_mem_rreq, i_mem_rrdy, i_mem_dout_vld, o_x_wen;
    logic [9:0]      o_mem_addr;
    logic [N*AW-1:0] i_mem_dout;
    logic [8:0]      o_x_addr;
    logic [XW-1:0]   o_x_data;

    gs_iter_solver #(.N(N), .ITER(ITER)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_module_en    (en),
        .i_mode         (mode),
        .i_matrix_num   (mnum),
        .o_proc_done    (o_proc_done),
        .o_mem_rreq     (o_mem_rreq),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rrdy     (i_mem_rrdy),
        .i_mem_dout     (i_mem_dout),
        .i_mem_dout_vld (i_mem_dout_vld),
        .o_x_wen        (o_x_wen),
        .o_x_addr       (o_x_addr),
        .o_x_data       (o_x_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int a; logic [31:0] d;} wr_t;
    wr_t               expq[$];
    logic [N*AW-1:0]   mem [1024];
    logic [31:0]       got [512];
    logic signed [31:0] xr [N];
    int checks, errors, wen_cnt, rreq_cnt;
    bit stall5;

    task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, g, e);
        end
    endtask

    function automatic logic signed [15:0] el(input logic [N*AW-1:0] w, input int j);
        return w[j*AW +: AW];
    endfunction

    task automatic set_el(input int a, input int j, input int v);
        mem[a][j*AW +: AW] = 16'(v);
    endtask

    // Solver written straight from the math: S over j!=i, fixed-point update, clamp, GS vs Jacobi.
    function automatic void model(input int m, input bit jac, input int iters);
        logic signed [31:0]  xo [N];
        logic signed [31:0]  xn [N];
        logic signed [31:0]  nx;
        logic signed [127:0] s, p;
        logic signed [15:0]  r, b;
        longint d, mx;
        for (int k = 0; k < N; k++) xo[k] = 0;
        for (int sw = 0; sw < iters; sw++) begin
            mx = 0;
            xn = xo;
            for (int i = 0; i < N; i++) begin
                s = 0;
                for (int j = 0; j < N; j++)
                    if (j != i) s = s + 128'(el(mem[m*(N+1)+i], j)) * 128'(xo[j]);
                r = el(mem[m*(N+1)+i], i);
                b = el(mem[m*(N+1)+N], i);
                p = (((128'(b) <<< 16) - s) * 128'(r)) >>> 14;
                if (r == 0) nx = 0;
                else if (p > 128'sd2147483647) nx = 32'h7FFFFFFF;
                else if (p < -128'sd2147483648) nx = 32'h80000000;
                else nx = p[31:0];
                d = longint'(nx) - longint'(xo[i]);
                if (d < 0) d = -d;
                if (d > mx) mx = d;
                if (jac) xn[i] = nx;
                else xo[i] = nx;
            end
            if (jac) xo = xn;
`ifdef GSIM_EARLY_STOP_EN
            if (sw >= 1 && mx <= 1) break;
`endif
        end
        xr = xo;
    endfunction

    task automatic gen_matrix(input int m, input int kind);
        int a, r;
        for (int i = 0; i <= N; i++) begin
            if (kind == 1) mem[m*(N+1)+i] = {$urandom, $urandom};
            else for (int j = 0; j < N; j++) set_el(m*(N+1)+i, j, int'($urandom_range(0, 6)) - 3);
        end
        if (kind == 1) return;
        for (int i = 0; i < N; i++) begin
            a = int'($urandom_range(2, 200));
            r = (16384 + a / 2) / a;
            if ($urandom_range(0, 1) == 1) r = -r;
            if (kind == 2 && $urandom_range(0, 2) == 0) r = 0;
            set_el(m*(N+1)+i, i, r);
            set_el(m*(N+1)+N, i, int'($urandom_range(0, 4000)) - 2000);
        end
    endtask

    // Memory port: programmable rrdy stall, 1-3 cycle read latency, single outstanding read.
    initial begin
        bit busy, pend;
        int need, waited, lat;
        logic [9:0] pa;
        i_mem_rrdy = 0; i_mem_dout_vld = 0; i_mem_dout = '0;
        busy = 0; pend = 0; need = 0; waited = 0; lat = 0; pa = '0;
        forever begin
            @(negedge clk);
            i_mem_dout_vld = 0;
            if (pend) begin
                if (lat == 0) begin
                    i_mem_dout = mem[pa];
                    i_mem_dout_vld = 1;
                    pend = 0;
                end else lat--;
            end
            if (o_mem_rreq && !pend && !rst) begin
                if (!busy) begin
                    busy = 1;
                    waited = 0;
                    need = stall5 ? 5 : int'($urandom_range(0, 2));
                end
                if (waited >= need) begin
                    i_mem_rrdy = 1;
                    busy = 0;
                    pend = 1;
                    pa = o_mem_addr;
                    lat = int'($urandom_range(0, 2));
                end else begin
                    i_mem_rrdy = 0;
                    waited++;
                end
            end else begin
                busy = 0;
                i_mem_rrdy = 1'($urandom_range(0, 1));
            end
        end
    end

    // Scoreboard: every write strobe must match the next modelled result in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_mem_rreq) rreq_cnt++;
            if (o_x_wen) begin
                wen_cnt++;
                got[o_x_addr] = o_x_data;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h", o_x_addr, o_x_data);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    if (o_x_addr != 9'(e.a) || o_x_data != e.d) begin
                        errors++;
                        $display("FAIL x_write got addr=%0d data=%h expected addr=%0d data=%h",
                                 o_x_addr, o_x_data, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic run_batch(input int mc, input bit jac, input bit st5);
        int cyc;
        stall5 = st5;
        for (int k = 0; k < 512; k++) got[k] = 32'hDEADBEEF;
        for (int m = 0; m < mc; m++) begin
            model(m, jac, ITER);
            for (int k = 0; k < N; k++) expq.push_back('{m*N + k, xr[k]});
        end
        @(negedge clk);
        mnum = 5'(mc); mode = jac; en = 1;
        @(negedge clk);
        mode = ~jac;
        cyc = 0;
        while (!o_proc_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("done_reached", o_proc_done, 1);
        chk("writes_left", expq.size(), 0);
        expq.delete();
        @(negedge clk);
        chk("done_held", o_proc_done, 1);
        en = 0;
        @(negedge clk);
        chk("done_cleared", o_proc_done, 0);
    endtask

    initial begin
        int w0, r0, dv;
        checks = 0; errors = 0; wen_cnt = 0; rreq_cnt = 0; stall5 = 0;
        rst = 1; en = 0; mode = 0; mnum = '0;
        for (int k = 0; k < 1024; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {o_proc_done, o_mem_rreq, o_x_wen}, 0);
        chk("reset_data", {o_mem_addr, o_x_addr, o_x_data}, 0);
        rst = 0;

        for (int i = 0; i < N; i++) begin
            set_el(i, i, 16'h4000);
            set_el(N, i, i + 1);
        end
        run_batch(1, 0, 0);
        for (int k = 0; k < N; k++) chk("identity_x", got[k], 64'(k + 1) << 16);

        for (int k = 0; k <= N; k++) mem[k] = '0;
        set_el(0, 0, 16'h2000); set_el(0, 1, 1);
        set_el(1, 0, 1);        set_el(1, 1, 16'h2000);
        set_el(2, 2, 16'h4000); set_el(3, 3, 16'h4000);
        set_el(N, 0, 3);        set_el(N, 1, 3);
        model(0, 0, 1);
        chk("model_gs_1sweep", {xr[0], xr[1]}, {32'h18000, 32'hC000});
        model(0, 1, 1);
        chk("model_jacobi_1sweep", {xr[0], xr[1]}, {32'h18000, 32'h18000});
        run_batch(1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            dv = int'(got[k]) - 32'h10000;
            checks++;
            if (dv > 2 || dv < -2) begin
                errors++;
                $display("FAIL gs_converge x%0d got=%h expected=00010000+-2", k, got[k]);
            end
        end
        run_batch(1, 1, 0);

        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k <= N; k++) mem[m*(N+1)+k] = '0;
            for (int i = 0; i < N; i++) begin
                set_el(m*(N+1)+i, i, 16'h7FFF);
                set_el(m*(N+1)+N, i, 32767);
            end
        end
        w0 = wen_cnt;
        run_batch(3, 0, 1);
        chk("sat_write_count", wen_cnt - w0, 3 * N);
        for (int k = 0; k < 3 * N; k++) chk("sat_x", got[k], 32'h7FFFFFFF);

        w0 = wen_cnt; r0 = rreq_cnt;
        @(negedge clk);
        mnum = '0; en = 1;
        @(negedge clk);
        chk("m0_done", o_proc_done, 1);
        en = 0;
        @(negedge clk);
        chk("m0_done_clear", o_proc_done, 0);
        chk("m0_no_traffic", {32'(rreq_cnt - r0), 32'(wen_cnt - w0)}, 0);

        for (int b = 0; b < 6; b++) begin
            int mc;
            mc = int'($urandom_range(1, 3));
            for (int m = 0; m < mc; m++) gen_matrix(m, int'($urandom_range(0, 2)));
            run_batch(mc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        gen_matrix(0, 0); gen_matrix(1, 0);
        w0 = wen_cnt;
        stall5 = 0;
        @(negedge clk);
        mnum = 5'd2; mode = 0; en = 1;
        repeat (40) @(negedge clk);
        en = 0;
        @(negedge clk);
        chk("abort_outputs", {o_mem_rreq, o_x_wen, o_proc_done}, 0);
        repeat (60) @(negedge clk);
        chk("abort_no_writes", wen_cnt - w0, 0);

        gen_matrix(0, 0);
        run_batch(1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
